// File: rtl/extmem_arbiter_pkg.sv
// rtl/extmem_arbiter_pkg.sv - shared types and constants for the external memory arbiter
package extmem_arb_pkg;

    localparam int ADR_W          = 13;
    localparam int DATA_W         = 32;
    localparam int BE_W           = 4;
    localparam int LINE_WORDS_DEF = 4;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        DACC,
        IBURST,
        TURN
    } arb_state_t;

endpackage

// File: rtl/extmem_arbiter_if.sv
// rtl/extmem_arbiter_if.sv - requester and memory-side signals of the arbiter
interface extmem_arbiter_if;
    import extmem_arb_pkg::*;

    logic              i_req;
    logic [ADR_W-1:0]  i_adr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;

    logic              d_req;
    logic              d_rwb;
    logic [ADR_W-1:0]  d_adr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_byteen;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic [ADR_W-1:0]  m_adr;
    logic [BE_W-1:0]   m_byteen;
    logic              m_rwb;
    logic              m_en;
    logic              m_drive;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_done;

    modport master (
        input  i_req, i_adr, d_req, d_rwb, d_adr, d_wdata, d_byteen, m_rdata, m_done,
        output i_ack, i_rdata, i_done, d_ack, d_rdata,
        output m_adr, m_byteen, m_rwb, m_en, m_drive, m_wdata
    );

    modport slave (
        output i_req, i_adr, d_req, d_rwb, d_adr, d_wdata, d_byteen, m_rdata, m_done,
        input  i_ack, i_rdata, i_done, d_ack, d_rdata,
        input  m_adr, m_byteen, m_rwb, m_en, m_drive, m_wdata
    );

endinterface

// File: rtl/extmem_arbiter_burst_ctr.sv
// rtl/extmem_arbiter_burst_ctr.sv - word index counter for refill bursts
module burst_ctr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = &cnt;

endmodule

// File: rtl/extmem_arbiter.sv
// rtl/extmem_arbiter.sv - shares the external memory port between icache refills and data accesses
module extmem_arbiter
    import extmem_arb_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic               ph1,
    input  logic               reset,
    extmem_arbiter_if.master   bus
);

    localparam int KW = $clog2(LINE_WORDS);
    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_t        state;
    logic [SW-1:0]     streak;
    logic [KW-1:0]     k_cnt;
    logic [KW-1:0]     k_nxt;
    logic              k_tc;
    logic              grant_d;
    logic              grant_i;

    logic [ADR_W-1:0]  m_adr_q;
    logic [BE_W-1:0]   m_byteen_q;
    logic              m_rwb_q;
    logic              m_en_q;
    logic              m_drive_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic              d_ack_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              i_ack_q;
    logic              i_done_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [KW-1:0]     unused_adr_lsb;

    assign unused_adr_lsb = bus.i_adr[KW-1:0];

    // Data wins ties until the refill has waited out STARVE_MAX data grants.
    assign grant_d = bus.d_req && (!bus.i_req || (streak < SW'(STARVE_MAX)));
    assign grant_i = bus.i_req && !grant_d;
    assign k_nxt   = k_cnt + KW'(1);

    burst_ctr #(.W(KW)) u_word_ctr (
        .clk   (ph1),
        .rst_n (reset),
        .clr   (state == IDLE),
        .en    ((state == IBURST) && bus.m_done),
        .cnt   (k_cnt),
        .tc    (k_tc)
    );

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            streak     <= '0;
            m_adr_q    <= '0;
            m_byteen_q <= '0;
            m_rwb_q    <= 1'b1;
            m_en_q     <= 1'b0;
            m_drive_q  <= 1'b0;
            m_wdata_q  <= '0;
            d_ack_q    <= 1'b0;
            d_rdata_q  <= '0;
            i_ack_q    <= 1'b0;
            i_done_q   <= 1'b0;
            i_rdata_q  <= '0;
        end else begin
            d_ack_q  <= 1'b0;
            i_ack_q  <= 1'b0;
            i_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state      <= DACC;
                        m_en_q     <= 1'b1;
                        m_adr_q    <= bus.d_adr;
                        m_rwb_q    <= bus.d_rwb;
                        m_byteen_q <= bus.d_rwb ? '0 : bus.d_byteen;
                        m_drive_q  <= !bus.d_rwb;
                        if (!bus.d_rwb) begin
                            m_wdata_q <= bus.d_wdata;
                        end
                        if (bus.i_req) begin
                            if (streak < SW'(STARVE_MAX)) begin
                                streak <= streak + SW'(1);
                            end
                        end else begin
                            streak <= '0;
                        end
                    end else if (grant_i) begin
                        state      <= IBURST;
                        m_en_q     <= 1'b1;
                        m_adr_q    <= {bus.i_adr[ADR_W-1:KW], {KW{1'b0}}};
                        m_rwb_q    <= 1'b1;
                        m_byteen_q <= '0;
                        m_drive_q  <= 1'b0;
                        streak     <= '0;
                    end
                end
                DACC: begin
                    if (bus.m_done) begin
                        state      <= TURN;
                        d_rdata_q  <= bus.m_rdata;
                        d_ack_q    <= 1'b1;
                        m_en_q     <= 1'b0;
                        m_drive_q  <= 1'b0;
                        m_rwb_q    <= 1'b1;
                        m_byteen_q <= '0;
                    end
                end
                IBURST: begin
                    if (bus.m_done) begin
                        i_rdata_q <= bus.m_rdata;
                        i_ack_q   <= 1'b1;
                        if (k_tc) begin
                            state    <= TURN;
                            i_done_q <= 1'b1;
                            m_en_q   <= 1'b0;
                        end else begin
                            m_adr_q <= {m_adr_q[ADR_W-1:KW], k_nxt};
                        end
                    end
                end
                TURN: begin
                    // Requests are deliberately ignored here so a requester can drop req on its ack.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m_adr    = m_adr_q;
    assign bus.m_byteen = m_byteen_q;
    assign bus.m_rwb    = m_rwb_q;
    assign bus.m_en     = m_en_q;
    assign bus.m_drive  = m_drive_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.i_ack    = i_ack_q;
    assign bus.i_done   = i_done_q;
    assign bus.i_rdata  = i_rdata_q;

endmodule
